// File: rtl/delta_sigma_pkg.sv
// Shared constants and helpers for the second-order delta-sigma DAC.
//
// Contents:
//   DATA_W, ACC_W, IN_LIMIT  default sample width, integrator width and input clamp
//   FS_POS / FS_NEG          feedback levels (+/- half of the input range)
//   LFSR_SEED / LFSR_TAPS    dither generator reset value and tap mask
//   sat_acc()                clamps a wide sum into a signed accW-bit range
//
// Optional feature macro: DELTA_SIGMA_DITHER_EN (see delta_sigma_dac.sv).
package delta_sigma_pkg;

    localparam int DATA_W   = 14;
    localparam int ACC_W    = 20;
    localparam int IN_LIMIT = 6144;

    localparam int FS_POS = 2 ** (DATA_W - 1);
    localparam int FS_NEG = -(2 ** (DATA_W - 1));

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map onto bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Clamp a 32-bit signed sum into the signed range of an accW-bit register.
    // The integrators never wrap: hitting either rail simply pins them there.
    function automatic logic signed [31:0] sat_acc(input logic signed [31:0] x,
                                                   input int accW);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (accW - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi) begin
            sat_acc = hi;
        end else if (x < lo) begin
            sat_acc = lo;
        end else begin
            sat_acc = x;
        end
    endfunction

endpackage

// File: rtl/ds_lfsr.sv
// 16-bit Fibonacci LFSR used as a tiny dither source for the modulator.
//
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset, loads LFSR_SEED
//   en_i    advance one step per cycle while high
//   lfsr_o  current register contents
module ds_lfsr
    import delta_sigma_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift right, feeding the XOR of the tapped bits back in at the top.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
        end
    end

    // State register; the non-zero seed keeps the LFSR out of its lock-up state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/delta_sigma_dac.sv
// Second-order 1-bit delta-sigma modulator: turns sporadic signed audio samples
// into a pulse-density bitstream for an external RC reconstruction filter.
// The loop runs every clock; the latest sample is held between valid strobes.
//
// Ports:
//   clk_i          system clock (50 MHz)
//   rst_ni         asynchronous active-low reset, clears all state
//   audio_valid_i  one-cycle strobe qualifying audio_i
//   audio_i        signed sample, clamped to +/-IN_LIMIT on capture
//   wave_o         registered 1-bit pulse-density output
//
// Optional feature macro: DELTA_SIGMA_DITHER_EN adds a 2-bit LFSR dither
// (-2..+1) to the held sample before the first integrator.
module delta_sigma_dac
    import delta_sigma_pkg::*;
#(
    parameter int DATA_W   = delta_sigma_pkg::DATA_W,
    parameter int ACC_W    = delta_sigma_pkg::ACC_W,
    parameter int IN_LIMIT = delta_sigma_pkg::IN_LIMIT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              audio_valid_i,
    input  logic [DATA_W-1:0] audio_i,
    output logic              wave_o
);

    logic signed [DATA_W-1:0] sample_q;
    logic signed [DATA_W-1:0] sample_d;
    logic signed [ACC_W-1:0]  int1_q;
    logic signed [ACC_W-1:0]  int1_d;
    logic signed [ACC_W-1:0]  int2_q;
    logic signed [ACC_W-1:0]  int2_d;
    logic                     wave_q;
    logic                     wave_d;

    logic signed [31:0] audioExt;
    logic signed [31:0] dither;
    logic signed [31:0] fbExt;
    logic signed [31:0] uExt;
    logic signed [31:0] int1Sum;
    logic signed [31:0] int2Sum;

    assign audioExt = 32'($signed(audio_i));

`ifdef DELTA_SIGMA_DITHER_EN
    logic [15:0] lfsrVal;

    ds_lfsr u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (1'b1),
        .lfsr_o (lfsrVal)
    );

    // The two LSBs read as a signed 2-bit value give a zero-ish mean nudge.
    assign dither = 32'($signed(lfsrVal[1:0]));
`else
    assign dither = '0;
`endif

    // Sample capture: clamp to +/-IN_LIMIT so the second-order loop stays
    // stable, and hold the value until the next valid strobe.
    always_comb begin
        sample_d = sample_q;
        if (audio_valid_i) begin
            if (audioExt > IN_LIMIT) begin
                sample_d = DATA_W'(IN_LIMIT);
            end else if (audioExt < -IN_LIMIT) begin
                sample_d = DATA_W'(-IN_LIMIT);
            end else begin
                sample_d = audio_i;
            end
        end
    end

    // Loop update: both integrators subtract the fed-back output level, and
    // the second one consumes the freshly computed first-integrator value.
    // The output bit is the sign of the new second integrator.
    always_comb begin
        fbExt   = wave_q ? 32'(FS_POS) : 32'(FS_NEG);
        uExt    = 32'(sample_q) + dither;
        int1Sum = 32'(int1_q) + uExt - fbExt;
        int1_d  = ACC_W'(sat_acc(int1Sum, ACC_W));
        int2Sum = 32'(int2_q) + 32'(int1_d) - fbExt;
        int2_d  = ACC_W'(sat_acc(int2Sum, ACC_W));
        wave_d  = ~int2_d[ACC_W-1];
    end

    // State registers; an asserted reset drops everything, including the
    // held sample, without waiting for a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q <= '0;
            int1_q   <= '0;
            int2_q   <= '0;
            wave_q   <= 1'b0;
        end else begin
            sample_q <= sample_d;
            int1_q   <= int1_d;
            int2_q   <= int2_d;
            wave_q   <= wave_d;
        end
    end

    assign wave_o = wave_q;

endmodule

// File: tb/tb_delta_sigma_dac.sv
// Self-checking bench for delta_sigma_dac: a cycle-level integer model of the
// modulator equations plus pulse-density checks derived from the mean
// transfer rule density = (u + 8192) / 16384.
module tb_delta_sigma_dac;

    logic        clk_i         = 1'b0;
    logic        rst_ni        = 1'b0;
    logic        audio_valid_i = 1'b0;
    logic [13:0] audio_i       = '0;
    logic        wave_o;

    int checks   = 0;
    int failures = 0;
    int bitErrs  = 0;

    int mSample = 0;
    int mInt1   = 0;
    int mInt2   = 0;
    int mWave   = 0;

`ifdef DELTA_SIGMA_DITHER_EN
    bit exactEn = 1'b0;
`else
    bit exactEn = 1'b1;
`endif

    // 50 MHz clock.
    always #10 clk_i = ~clk_i;

    delta_sigma_dac dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .audio_valid_i (audio_valid_i),
        .audio_i       (audio_i),
        .wave_o        (wave_o)
    );

    function automatic int clampRef(int v, int lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic int expDensity(int v, int win);
        return ((clampRef(v, 6144) + 8192) * win) / 16384;
    endfunction

    // Reference modulator in plain integers: held sample, two saturating
    // integrators and a sign decision, cleared asynchronously by reset.
    always @(posedge clk_i or negedge rst_ni) begin
        int fb;
        int a;
        if (!rst_ni) begin
            mSample = 0;
            mInt1   = 0;
            mInt2   = 0;
            mWave   = 0;
        end else begin
            fb    = (mWave != 0) ? 8192 : -8192;
            mInt1 = clampRef(mInt1 + mSample - fb, 524288);
            if (mInt1 == 524288) mInt1 = 524287;
            mInt2 = clampRef(mInt2 + mInt1 - fb, 524288);
            if (mInt2 == 524288) mInt2 = 524287;
            mWave = (mInt2 >= 0) ? 1 : 0;
            if (audio_valid_i) begin
                a       = $signed(audio_i);
                mSample = clampRef(a, 6144);
            end
        end
    end

    // Compare every output bit against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (rst_ni && exactEn && (int'(wave_o) != mWave)) bitErrs++;
    end

    task automatic checkOutput(string tag, int observed, int expected, int tol);
        checks++;
        if (observed < expected - tol || observed > expected + tol) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d +/- %0d",
                     tag, observed, expected, tol);
        end
    endtask

    task automatic applyStimulus(int value);
        @(negedge clk_i);
        audio_valid_i = 1'b1;
        audio_i       = 14'(value);
        @(negedge clk_i);
        audio_valid_i = 1'b0;
    endtask

    task automatic countOnes(int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk_i);
            ones += int'(wave_o);
        end
    endtask

    initial begin
        int ones;
        int errs;
        int waited;
        int v;
        bit bits[64];
        int per2;

        $display("[TB] start");

        // Reset held with strobes toggling: output must stay low.
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            audio_valid_i = i[0];
            audio_i       = 14'd4096;
            if (wave_o !== 1'b0) errs++;
        end
        checkOutput("reset_wave_low", errs, 0, 0);
        audio_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        countOnes(1024, ones);
        checkOutput("zero_after_reset", ones, 512, 2);

        // DC levels, then clamped extremes.
        applyStimulus(4096);
        repeat (200) @(negedge clk_i);
        countOnes(1024, ones);
        checkOutput("dc_pos4096", ones, 768, 4);

        applyStimulus(-4096);
        repeat (200) @(negedge clk_i);
        countOnes(1024, ones);
        checkOutput("dc_neg4096", ones, 256, 4);

        applyStimulus(8191);
        repeat (200) @(negedge clk_i);
        countOnes(1024, ones);
        checkOutput("clamp_pos", ones, 896, 4);

        applyStimulus(-8192);
        repeat (200) @(negedge clk_i);
        countOnes(1024, ones);
        checkOutput("clamp_neg", ones, 128, 4);

        // Valid gating: data changes with valid low must be ignored.
        applyStimulus(4096);
        audio_i = 14'(-4096);
        countOnes(1024, ones);
        countOnes(1024, ones);
        checkOutput("gated_hold", ones, 768, 4);
        applyStimulus(-4096);
        repeat (300) @(negedge clk_i);
        countOnes(1024, ones);
        checkOutput("gated_update", ones, 256, 4);

        // Asynchronous reset between clock edges while the output is high.
        applyStimulus(4096);
        repeat (200) @(negedge clk_i);
        waited = 0;
        while (wave_o !== 1'b1 && waited < 16) begin
            @(negedge clk_i);
            waited++;
        end
        checkOutput("wave_high_before_reset", int'(wave_o), 1, 0);
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1 checkOutput("async_reset_wave", int'(wave_o), 0, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        countOnes(1024, ones);
        checkOutput("sample_cleared", ones, 512, 2);

        // Random DC levels over the full input range, random data while idle.
        for (int t = 0; t < 6; t++) begin
            v = int'($urandom_range(0, 16383)) - 8192;
            applyStimulus(v);
            audio_i = 14'($urandom);
            repeat (200) @(negedge clk_i);
            countOnes(1024, ones);
            checkOutput($sformatf("random_dc_%0d", v), ones, expDensity(v, 1024), 4);
        end

        // One period of a 1 kHz full-scale sine, one sample per 1000 cycles.
        for (int k = 0; k < 50; k++) begin
            v = $rtoi(8191.0 * $sin(2.0 * 3.14159265358979 * k / 50.0));
            applyStimulus(v);
            repeat (486) @(negedge clk_i);
            countOnes(512, ones);
            checkOutput($sformatf("sine_%0d", k), ones, expDensity(v, 512), 10);
        end

`ifdef DELTA_SIGMA_DITHER_EN
        // Zero input with dither: no period-2 pattern over 64 cycles.
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (64) @(negedge clk_i);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_i);
            bits[i] = wave_o;
        end
        per2 = 1;
        for (int i = 0; i < 62; i++) begin
            if (bits[i] != bits[i+2]) per2 = 0;
        end
        checkOutput("dither_no_period2", per2, 0, 0);
`else
        per2 = 0;
        bits[0] = 1'b0;
`endif

        checkOutput("bitexact_model", bitErrs, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
